// File: rtl/mesi_pkg.sv
// Shared encodings for the MESI snooping-bus slice: bus messages, memory
// commands, cache line states and the bus arbiter's sequencing states.
package mesi_pkg;

    localparam int BUS_W = 2;
    localparam int MEM_W = 2;

    typedef enum logic [BUS_W-1:0] {
        BUS_NONE       = 2'b00,
        BUS_READ_MISS  = 2'b01,
        BUS_WRITE_MISS = 2'b10,
        BUS_INVALIDATE = 2'b11
    } bus_code_e;

    typedef enum logic [MEM_W-1:0] {
        MEM_NONE = 2'b00,
        MEM_READ = 2'b01,
        MEM_WB   = 2'b10
    } mem_code_e;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_state_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BROADCAST,
        ST_SNOOP,
        ST_WRITEBACK,
        ST_MEMREAD,
        ST_DONE
    } arb_state_e;

endpackage

// File: rtl/mesi_bus_arbiter_if.sv
// Snooping-bus bundle between the cache controllers, the shared memory port
// and the bus arbiter; slave is the arbiter's view, master the caches' view.
interface mesi_bus_arbiter_if
    import mesi_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) ();

    logic [2*N-1:0]  req_msg;
    logic [N-1:0]    wb_req;
    logic            mem_ready;
    logic [N-1:0]    grant;
    bus_code_e       bus_msg;
    logic [IDXW-1:0] bus_src;
    logic [N-1:0]    snoop_valid;
    mem_code_e       mem_cmd;
    logic [IDXW-1:0] mem_src;
    logic [N-1:0]    done;
    logic            busy;

    modport slave (
        input  req_msg, wb_req, mem_ready,
        output grant, bus_msg, bus_src, snoop_valid, mem_cmd, mem_src, done, busy
    );

    modport master (
        output req_msg, wb_req, mem_ready,
        input  grant, bus_msg, bus_src, snoop_valid, mem_cmd, mem_src, done, busy
    );

endinterface

// File: rtl/mesi_bus_arbiter_rr_arbiter.sv
// Combinational rotate-priority encoder: picks the first requester strictly
// after 'last', wrapping modulo N. Reusable for any shared resource.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] last,
    output logic [IDXW-1:0] gnt_idx,
    output logic            any
);

    int idx;

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = IDXW'(idx);
            end
        end
    end

endmodule

// File: rtl/mesi_bus_arbiter.sv
// Snooping-bus arbiter: grants one cache per transaction in round-robin order,
// broadcasts its message, runs an optional snooper write-back and the block read.
module mesi_bus_arbiter
    import mesi_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input logic               clock,
    input logic               Reset,
    mesi_bus_arbiter_if.slave bus
);

    arb_state_e      state_q, state_d;
    bus_code_e       msg_q, win_msg;
    logic [IDXW-1:0] src_q, last_q, mem_src_q, arb_idx, wb_idx;
    logic [N-1:0]    pending, src_oh, wb_masked;
    logic            arb_any, wb_any;

    logic [N-1:0]    grant_o, snoop_o, done_o;
    bus_code_e       bus_msg_o;
    mem_code_e       mem_cmd_o;

    always_comb begin
        pending = '0;
        win_msg = BUS_NONE;
        for (int i = 0; i < N; i++) begin
            pending[i] = |bus.req_msg[2*i +: 2];
            if (arb_idx == IDXW'(i)) win_msg = bus_code_e'(bus.req_msg[2*i +: 2]);
        end
    end

    rr_arbiter #(.N(N), .IDXW(IDXW)) u_rr (
        .req     (pending),
        .last    (last_q),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // The owner never writes back to itself; extra snoopers are a protocol
    // violation and only the lowest index is honoured.
    always_comb begin
        src_oh         = '0;
        src_oh[src_q]  = 1'b1;
        wb_masked      = bus.wb_req & ~src_oh;
        wb_any         = |wb_masked;
        wb_idx         = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (wb_masked[i]) wb_idx = IDXW'(i);
        end
    end

    always_ff @(posedge clock or posedge Reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (arb_any) state_d = ST_BROADCAST;
            ST_BROADCAST: state_d = ST_SNOOP;
            ST_SNOOP: begin
                if (wb_any)                       state_d = ST_WRITEBACK;
                else if (msg_q == BUS_INVALIDATE) state_d = ST_DONE;
                else                              state_d = ST_MEMREAD;
            end
            ST_WRITEBACK: begin
                if (bus.mem_ready) state_d = (msg_q == BUS_INVALIDATE) ? ST_DONE : ST_MEMREAD;
            end
            ST_MEMREAD:   if (bus.mem_ready) state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Transaction context: captured once and held until the next arbitration.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            msg_q     <= BUS_NONE;
            src_q     <= '0;
            last_q    <= IDXW'(N - 1);
            mem_src_q <= '0;
        end else begin
            if (state_q == ST_IDLE && arb_any) begin
                msg_q <= win_msg;
                src_q <= arb_idx;
            end
            if (state_q == ST_SNOOP && wb_any) mem_src_q <= wb_idx;
            if (state_q == ST_DONE)            last_q    <= src_q;
        end
    end

    // Outputs depend only on state and registered context, never on inputs.
    always_comb begin
        grant_o   = '0;
        snoop_o   = '0;
        done_o    = '0;
        bus_msg_o = BUS_NONE;
        mem_cmd_o = MEM_NONE;
        if (state_q != ST_IDLE) grant_o = src_oh;
        unique case (state_q)
            ST_BROADCAST: begin
                bus_msg_o = msg_q;
                snoop_o   = ~src_oh;
            end
            ST_WRITEBACK: mem_cmd_o = MEM_WB;
            ST_MEMREAD:   mem_cmd_o = MEM_READ;
            ST_DONE:      done_o    = src_oh;
            default: ;
        endcase
    end

    assign bus.grant       = grant_o;
    assign bus.bus_msg     = bus_msg_o;
    assign bus.bus_src     = (state_q != ST_IDLE) ? src_q : '0;
    assign bus.snoop_valid = snoop_o;
    assign bus.mem_cmd     = mem_cmd_o;
    assign bus.mem_src     = mem_src_q;
    assign bus.done        = done_o;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Self-checking bench for mesi_bus_arbiter: directed vector table, hand-written
// corner sequences and randomized transactions against a transaction-level model.
module tb_mesi_bus_arbiter;
    import mesi_pkg::*;

    localparam int N    = 4;
    localparam int IDXW = 2;

    localparam int PH_IDLE = 0;
    localparam int PH_BC   = 1;
    localparam int PH_SN   = 2;
    localparam int PH_WB   = 3;
    localparam int PH_MR   = 4;
    localparam int PH_DONE = 5;

    typedef struct packed {
        logic [N-1:0]    grant;
        logic [1:0]      bus_msg;
        logic [IDXW-1:0] bus_src;
        logic [N-1:0]    snoop_valid;
        logic [1:0]      mem_cmd;
        logic [IDXW-1:0] mem_src;
        logic [N-1:0]    done;
        logic            busy;
    } outs_t;

    typedef struct {
        logic [2*N-1:0] req;
        logic [N-1:0]   wb;
        logic           rdy;
        outs_t          exp;
        string          name;
    } vec_t;

    logic clock = 1'b0;
    logic Reset;
    always #5 clock = ~clock;

    mesi_bus_arbiter_if #(.N(N)) bus ();

    mesi_bus_arbiter #(.N(N), .IDXW(IDXW)) dut (
        .clock (clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: held request per cache, write-back pattern, last owner,
    // and the most recently latched write-back source.
    logic [1:0]   p_msg [N];
    logic [N-1:0] wb_pat;
    int           m_last;
    int           m_msrc;
    bit           rand_mode;
    vec_t         vecs[$];

    function automatic outs_t sample();
        outs_t s;
        s.grant       = bus.grant;
        s.bus_msg     = bus.bus_msg;
        s.bus_src     = bus.bus_src;
        s.snoop_valid = bus.snoop_valid;
        s.mem_cmd     = bus.mem_cmd;
        s.mem_src     = bus.mem_src;
        s.done        = bus.done;
        s.busy        = bus.busy;
        return s;
    endfunction

    task automatic check(input string name, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got grant=%b msg=%b src=%0d snoop=%b cmd=%b msrc=%0d done=%b busy=%b; expected grant=%b msg=%b src=%0d snoop=%b cmd=%b msrc=%0d done=%b busy=%b",
                     name, got.grant, got.bus_msg, got.bus_src, got.snoop_valid, got.mem_cmd,
                     got.mem_src, got.done, got.busy, exp.grant, exp.bus_msg, exp.bus_src,
                     exp.snoop_valid, exp.mem_cmd, exp.mem_src, exp.done, exp.busy);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic outs_t o(input logic [N-1:0] g, input logic [1:0] msg, input int src,
                                input logic [N-1:0] snp, input logic [1:0] cmd, input int msrc,
                                input logic [N-1:0] dn, input logic bsy);
        outs_t r;
        r.grant = g; r.bus_msg = msg; r.bus_src = IDXW'(src); r.snoop_valid = snp;
        r.mem_cmd = cmd; r.mem_src = IDXW'(msrc); r.done = dn; r.busy = bsy;
        return r;
    endfunction

    // Expected outputs for one transaction phase with owner w and message m.
    function automatic outs_t mk(input int ph, input int w, input logic [1:0] m);
        outs_t r;
        r = '0;
        r.mem_src = IDXW'(m_msrc);
        if (ph != PH_IDLE) begin
            r.grant   = oh(w);
            r.bus_src = IDXW'(w);
            r.busy    = 1'b1;
        end
        if (ph == PH_BC) begin
            r.bus_msg     = m;
            r.snoop_valid = ~oh(w);
        end
        if (ph == PH_WB)   r.mem_cmd = 2'b10;
        if (ph == PH_MR)   r.mem_cmd = 2'b01;
        if (ph == PH_DONE) r.done    = oh(w);
        return r;
    endfunction

    function automatic logic rnd_rdy();
        return rand_mode ? 1'($urandom_range(1)) : 1'b0;
    endfunction

    task automatic add(input logic [2*N-1:0] req, input logic [N-1:0] wb, input logic rdy,
                       input outs_t exp, input string name);
        vec_t v;
        v.req = req; v.wb = wb; v.rdy = rdy; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    // One clock cycle: drive inputs just after the edge, check at the falling edge.
    task automatic drive_and_check(input string name, input outs_t exp, input logic rdy);
        if (rand_mode && exp.busy) begin
            for (int i = 0; i < N; i++)
                if (p_msg[i] == 2'b00 && $urandom_range(7) == 0)
                    p_msg[i] = 2'($urandom_range(3, 1));
        end
        for (int i = 0; i < N; i++) bus.req_msg[2*i +: 2] = p_msg[i];
        bus.wb_req    = wb_pat;
        bus.mem_ready = rdy;
        @(negedge clock);
        check(name, sample(), exp);
        @(posedge clock);
        #1;
    endtask

    // Whole transaction from the arbitration cycle to DONE, from the rules:
    // round-robin winner after the last owner, optional write-back, read unless invalidate.
    task automatic run_txn(input string tag, input int wbw, input int mrw);
        int         w;
        int         wbi;
        logic [1:0] m;
        w = -1;
        for (int k = 1; k <= N; k++) begin
            if (w < 0 && p_msg[(m_last + k) % N] != 2'b00) w = (m_last + k) % N;
        end
        if (w < 0) begin
            drive_and_check({tag, " idle"}, mk(PH_IDLE, 0, 2'b00), rnd_rdy());
            return;
        end
        m   = p_msg[w];
        wbi = -1;
        for (int i = 0; i < N; i++) if (wbi < 0 && i != w && wb_pat[i]) wbi = i;
        drive_and_check({tag, " arb"},       mk(PH_IDLE, w, m), rnd_rdy());
        drive_and_check({tag, " broadcast"}, mk(PH_BC,   w, m), rnd_rdy());
        drive_and_check({tag, " snoop"},     mk(PH_SN,   w, m), rnd_rdy());
        if (wbi >= 0) begin
            m_msrc = wbi;
            for (int j = 0; j <= wbw; j++)
                drive_and_check({tag, " writeback"}, mk(PH_WB, w, m), j == wbw);
        end
        if (m != 2'b11) begin
            for (int j = 0; j <= mrw; j++)
                drive_and_check({tag, " memread"}, mk(PH_MR, w, m), j == mrw);
        end
        drive_and_check({tag, " done"}, mk(PH_DONE, w, m), rnd_rdy());
        m_last   = w;
        p_msg[w] = (rand_mode && $urandom_range(2) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
    endtask

    task automatic model_reset();
        m_last = N - 1;
        m_msrc = 0;
        for (int i = 0; i < N; i++) p_msg[i] = 2'b00;
        wb_pat = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rand_mode = 1'b0;
        model_reset();

        // Cache 1 read miss, zero-wait memory: done on the 4th edge.
        add(8'b0000_0100, 4'b0000, 1'b1, o(4'b0000, 2'b00, 0, 4'b0000, 2'b00, 0, 4'b0000, 1'b0), "rd arb");
        add(8'b0000_0100, 4'b0000, 1'b1, o(4'b0010, 2'b01, 1, 4'b1101, 2'b00, 0, 4'b0000, 1'b1), "rd broadcast");
        add(8'b0000_0100, 4'b0000, 1'b1, o(4'b0010, 2'b00, 1, 4'b0000, 2'b00, 0, 4'b0000, 1'b1), "rd snoop");
        add(8'b0000_0100, 4'b0000, 1'b1, o(4'b0010, 2'b00, 1, 4'b0000, 2'b01, 0, 4'b0000, 1'b1), "rd memread");
        add(8'b0000_0100, 4'b0000, 1'b1, o(4'b0010, 2'b00, 1, 4'b0000, 2'b00, 0, 4'b0010, 1'b1), "rd done");
        add(8'b0000_0000, 4'b0000, 1'b1, o(4'b0000, 2'b00, 0, 4'b0000, 2'b00, 0, 4'b0000, 1'b0), "rd idle");
        // Cache 3 invalidate, no write-back: no memory command, done on the 3rd edge.
        add(8'b1100_0000, 4'b0000, 1'b1, o(4'b0000, 2'b00, 0, 4'b0000, 2'b00, 0, 4'b0000, 1'b0), "inv arb");
        add(8'b1100_0000, 4'b0000, 1'b1, o(4'b1000, 2'b11, 3, 4'b0111, 2'b00, 0, 4'b0000, 1'b1), "inv broadcast");
        add(8'b1100_0000, 4'b0000, 1'b1, o(4'b1000, 2'b00, 3, 4'b0000, 2'b00, 0, 4'b0000, 1'b1), "inv snoop");
        add(8'b1100_0000, 4'b0000, 1'b1, o(4'b1000, 2'b00, 3, 4'b0000, 2'b00, 0, 4'b1000, 1'b1), "inv done");
        add(8'b0000_0000, 4'b0000, 1'b1, o(4'b0000, 2'b00, 0, 4'b0000, 2'b00, 0, 4'b0000, 1'b0), "inv idle");

        Reset         = 1'b1;
        bus.req_msg   = '0;
        bus.wb_req    = '0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset values", sample(), '0);
        @(posedge clock);
        #1;
        Reset = 1'b0;

        foreach (vecs[k]) begin
            bus.req_msg   = vecs[k].req;
            bus.wb_req    = vecs[k].wb;
            bus.mem_ready = vecs[k].rdy;
            @(negedge clock);
            check(vecs[k].name, sample(), vecs[k].exp);
            @(posedge clock);
            #1;
        end
        m_last = 3;

        // Simultaneous write misses from 0, 2, 3, then 0 and 1 after 3.
        p_msg[0] = 2'b10; p_msg[2] = 2'b10; p_msg[3] = 2'b10;
        run_txn("rr first", 0, 0);
        run_txn("rr second", 0, 0);
        run_txn("rr third", 0, 0);
        p_msg[0] = 2'b10; p_msg[1] = 2'b10;
        run_txn("rr wrap", 0, 0);
        run_txn("rr tail", 0, 0);

        // Cache 2 read miss with snooper 0 writing back; own bit 2 ignored.
        p_msg[2] = 2'b01; wb_pat = 4'b0101;
        run_txn("wb", 1, 0);
        wb_pat = '0;

        // Memory stalls five cycles during the block read.
        p_msg[1] = 2'b01;
        run_txn("stall", 0, 5);

        // Reset pulsed during a write-back.
        p_msg[2] = 2'b01; wb_pat = 4'b0010;
        drive_and_check("rst arb",       mk(PH_IDLE, 2, 2'b01), 1'b0);
        drive_and_check("rst broadcast", mk(PH_BC,   2, 2'b01), 1'b0);
        drive_and_check("rst snoop",     mk(PH_SN,   2, 2'b01), 1'b0);
        m_msrc = 1;
        drive_and_check("rst writeback", mk(PH_WB,   2, 2'b01), 1'b0);
        drive_and_check("rst writeback", mk(PH_WB,   2, 2'b01), 1'b0);
        Reset = 1'b1;
        #1;
        check("rst async clear", sample(), '0);
        @(negedge clock);
        check("rst held", sample(), '0);
        @(posedge clock);
        #1;
        Reset = 1'b0;
        model_reset();
        p_msg[0] = 2'b10; p_msg[2] = 2'b01;
        run_txn("post-rst first", 0, 0);
        run_txn("post-rst second", 0, 0);

        // Randomized traffic against the transaction model.
        rand_mode = 1'b1;
        for (int t = 0; t < 150; t++) begin
            wb_pat = ($urandom_range(2) == 0) ? 4'($urandom) : 4'b0000;
            for (int i = 0; i < N; i++)
                if (p_msg[i] == 2'b00 && $urandom_range(1) == 1)
                    p_msg[i] = 2'($urandom_range(3, 1));
            run_txn("rand", $urandom_range(3), $urandom_range(3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
